// File: rtl/bf_uart_pkg.sv
// bf_uart_pkg: constants and types shared by the UART transmit queue.
//   UART_W     : width of one UART byte
//   tx_state_e : transmit FSM state encodings (IDLE, SEND, GUARD)
package bf_uart_pkg;

    localparam int UART_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular-buffer byte queue with DEPTH_LOG2+1 bit pointers.
// Optional feature macro: UART_TXQ_LEVEL_EN adds the 'level' output.
// Ports:
//   CLK, RESET : clock, synchronous active-low reset (pointers only)
//   push, din  : write request and data; ignored while full
//   pop, dout  : read request and head-of-queue data; ignored while empty
//   full,empty : combinational from the registered pointers
//   level      : (UART_TXQ_LEVEL_EN) wptr - rptr
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
`ifdef UART_TXQ_LEVEL_EN
    ,
    output logic [DEPTH_LOG2:0] level
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wptr, rptr;
    logic                do_push, do_pop;

    // The extra pointer MSB distinguishes full from empty when the
    // index bits match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]) &&
                   (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]);

    // full comes from registered pointers, so a same-cycle pop never
    // frees a slot for the write.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign dout = mem[rptr[DEPTH_LOG2-1:0]];

`ifdef UART_TXQ_LEVEL_EN
    assign level = wptr - rptr;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    // Storage carries no reset; stale contents are unreachable once the
    // pointers are cleared.
    always_ff @(posedge CLK) begin
        if (RESET && do_push) mem[wptr[DEPTH_LOG2-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: buffers CPU output bytes and feeds them one at a time to
// a UART transmitter, with a guard cycle between strobes.
// Optional feature macro: UART_TXQ_LEVEL_EN adds the LEVEL output.
// Ports:
//   CLK, RESET      : clock, synchronous active-low reset
//   IN, WR          : CPU byte and write strobe
//   FULL, EMPTY     : queue status
//   OVF             : sticky, set by a write while FULL; cleared by reset
//   UART_DATA       : byte presented to the UART, held until next send
//   UART_WR         : one-cycle transmit strobe
//   UART_RDY        : UART idle, may accept a byte
//   LEVEL           : (UART_TXQ_LEVEL_EN) number of queued bytes
module uart_tx_queue
    import bf_uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [UART_W-1:0] IN,
    input  logic              WR,
    output logic              FULL,
    output logic              EMPTY,
    output logic              OVF,
    output logic [UART_W-1:0] UART_DATA,
    output logic              UART_WR,
    input  logic              UART_RDY
`ifdef UART_TXQ_LEVEL_EN
    ,
    output logic [DEPTH_LOG2:0] LEVEL
`endif
);

    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 8) begin : g_bad_depth
        $error("uart_tx_queue: DEPTH_LOG2 must be in 1..8");
    end

    tx_state_e         state;
    logic [UART_W-1:0] head;
    logic              pop;

    // Pop exactly on the edge that takes IDLE into SEND.
    assign pop = (state == IDLE) && !EMPTY && UART_RDY;

    sync_fifo #(
        .WIDTH      (UART_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (WR),
        .pop   (pop),
        .din   (IN),
        .dout  (head),
        .full  (FULL),
        .empty (EMPTY)
`ifdef UART_TXQ_LEVEL_EN
        ,
        .level (LEVEL)
`endif
    );

    // SEND -> GUARD -> IDLE spaces strobes at least three cycles apart and
    // gives the UART time to drop UART_RDY before it is looked at again.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= IDLE;
            UART_WR   <= 1'b0;
            UART_DATA <= '0;
            OVF       <= 1'b0;
        end else begin
            if (WR && FULL) OVF <= 1'b1;
            case (state)
                IDLE: begin
                    if (pop) begin
                        UART_DATA <= head;
                        UART_WR   <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    UART_WR <= 1'b0;
                    state   <= GUARD;
                end
                GUARD: begin
                    state <= IDLE;
                end
                default: begin
                    UART_WR <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter DEPTH_LOG2, default 4, SHALL set the queue depth to 2^DEPTH_LOG2 bytes; the legal range is 1..8.
REQ-003 Port CLK, input, 1 bit: the system clock; all state SHALL update on its rising edge.
REQ-004 Port RESET, input, 1 bit: synchronous, active-low reset; a 0 sampled on a CLK edge resets the block.
REQ-005 Port IN, input, 8 bits: the byte from the CPU output instruction.
REQ-006 Port WR, input, 1 bit: CPU write strobe; IN is sampled when WR=1.
REQ-007 Port FULL, output, 1 bit: the queue holds 2^DEPTH_LOG2 bytes.
REQ-008 Port EMPTY, output, 1 bit: the queue holds 0 bytes.
REQ-009 Port OVF, output, 1 bit: sticky flag, set when a write arrives while FULL=1.
REQ-010 Port UART_DATA, output, 8 bits: the byte presented to the UART transmitter input.
REQ-011 Port UART_WR, output, 1 bit: one-cycle transmit strobe to the UART.
REQ-012 Port UART_RDY, input, 1 bit: the UART is idle and can accept a byte.

Function
REQ-013 A write SHALL be accepted on an edge where WR=1 and FULL=1 is not set in that cycle; a pop in the same cycle SHALL NOT make room for that write.
REQ-014 A write with FULL=1 SHALL be discarded, leave the queue unchanged, and set OVF=1.
REQ-015 Storage SHALL be a circular buffer: the write and read pointers are DEPTH_LOG2+1 bits wide and wrap modulo 2^(DEPTH_LOG2+1).
REQ-016 FULL and EMPTY SHALL be derived combinationally from the registered pointers.
- EMPTY: pointers are equal.
- FULL: low DEPTH_LOG2 bits are equal and the MSBs differ.
REQ-017 The FSM SHALL have exactly three states: IDLE, SEND and GUARD.
REQ-018 In IDLE, if EMPTY=0 and UART_RDY=1, the next edge SHALL:
- load the head byte into UART_DATA;
- advance the read pointer;
- enter SEND.
REQ-019 In SEND, UART_WR SHALL be 1; the next edge SHALL enter GUARD unconditionally.
REQ-020 In GUARD, UART_RDY SHALL be ignored and UART_WR SHALL be 0; the next edge SHALL enter IDLE.
REQ-021 UART_WR SHALL be 0 in every state other than SEND, so every UART_WR pulse lasts exactly one cycle.
REQ-022 Consecutive UART_WR pulses SHALL be at least 3 cycles apart.
REQ-023 Pop latency: for a write accepted at edge E0 into an empty queue with UART_RDY=1, UART_WR SHALL be high between E1 and E2.
REQ-024 UART_DATA SHALL hold its value until the next transition into SEND.
REQ-025 A simultaneous write and pop SHALL both take effect, except as limited by REQ-013.
REQ-026 A write to an empty queue SHALL NOT bypass storage.
REQ-027 Bytes SHALL leave in the order they were accepted.
REQ-028 OVF SHALL be cleared only by reset.

Reset
REQ-029 On reset the block SHALL set:
- both pointers to 0;
- the FSM state to IDLE;
- UART_WR=0, UART_DATA=8'h00, OVF=0;
- EMPTY=1, FULL=0.
REQ-030 Reset mid-operation SHALL discard all queued bytes; a byte already strobed into the UART is not recalled.
REQ-031 Queue memory contents SHALL NOT need reset.

Configuration
REQ-032 The feature macro is UART_TXQ_LEVEL_EN.
REQ-033 With UART_TXQ_LEVEL_EN defined, the block SHALL add output LEVEL, DEPTH_LOG2+1 bits, equal to the write pointer minus the read pointer, modulo 2^(DEPTH_LOG2+1).
REQ-034 LEVEL SHALL be 0 on reset and 2^DEPTH_LOG2 when FULL=1.
REQ-035 With UART_TXQ_LEVEL_EN undefined, LEVEL and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-036 The FSM state encodings (IDLE=2'd0, SEND=2'd1, GUARD=2'd2) SHALL live in shared package bf_uart_pkg, together with the UART byte width constant (8).
REQ-037 Pointer and storage logic SHALL be a sub-module named sync_fifo, parameterised by width and DEPTH_LOG2.
- It SHALL expose push, pop, data in, data out, full and empty.
- It SHALL expose a level output when UART_TXQ_LEVEL_EN is defined.
REQ-038 The FSM SHALL live in uart_tx_queue.

Verification
REQ-039 Single byte: reset, hold UART_RDY=1, write 8'h41 once. UART_WR SHALL pulse one cycle, one edge after the write, with UART_DATA=8'h41; EMPTY SHALL return to 1.
REQ-040 Fill and overflow (DEPTH_LOG2=4): hold UART_RDY=0 and write 8'h00..8'h10 (17 bytes). FULL SHALL be 1 after 16 bytes and OVF SHALL be 1 after the 17th. Then release UART_RDY: output SHALL be 8'h00..8'h0F in order, and 8'h10 SHALL never appear.
REQ-041 Back-pressure: toggle UART_RDY low for 100 cycles after each UART_WR. Each strobe SHALL occur only from IDLE with UART_RDY=1, and SHALL be at least 3 cycles after the previous strobe.
REQ-042 Simultaneous push and pop when FULL=1: with 16 queued bytes, a write in the pop cycle SHALL be discarded and set OVF. With 15 queued bytes, a write in the pop cycle SHALL be accepted and LEVEL SHALL stay 15.
REQ-043 Wrap-around: stream 100 bytes through a 16-deep queue with random UART_RDY. The output sequence SHALL equal the input sequence.
REQ-044 Reset mid-stream: with 5 bytes queued and the FSM in GUARD, assert reset. The next cycle SHALL show EMPTY=1, UART_WR=0, OVF=0 and LEVEL=0, and no further UART_WR SHALL occur.
